// File: rtl/tone_band_classifier.sv
// Tone band classifier: measures the period between rising edges of a squared tone and
// asserts one of four band-present levels after a run of consistent in-band periods.
module tone_band_classifier #(
  parameter int CNT_W   = 17,
  parameter int B1_LO   = 47500,
  parameter int B1_HI   = 52500,
  parameter int B2_LO   = 31667,
  parameter int B2_HI   = 35000,
  parameter int B3_LO   = 23750,
  parameter int B3_HI   = 26250,
  parameter int B4_LO   = 19000,
  parameter int B4_HI   = 21000,
  parameter int TIMEOUT = 60000,
  parameter int MATCH_N = 8,
  parameter int MISS_N  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic             pb1,
  output logic             pb2,
  output logic             pb3,
  output logic             pb4,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid
);
  localparam int MW = $clog2(MATCH_N + 1);
  localparam int SW = $clog2(MISS_N + 1);
  localparam logic [CNT_W-1:0] L1 = CNT_W'(B1_LO), H1 = CNT_W'(B1_HI);
  localparam logic [CNT_W-1:0] L2 = CNT_W'(B2_LO), H2 = CNT_W'(B2_HI);
  localparam logic [CNT_W-1:0] L3 = CNT_W'(B3_LO), H3 = CNT_W'(B3_HI);
  localparam logic [CNT_W-1:0] L4 = CNT_W'(B4_LO), H4 = CNT_W'(B4_HI);
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    MATCH_V = MW'(MATCH_N);
  localparam logic [SW-1:0]    MISS_V  = SW'(MISS_N);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t            state, state_nx;
  logic [2:0]        sync;
  logic              rise;
  logic [CNT_W-1:0]  cnt, cnt_nx, per_nx;
  logic [2:0]        band, cand, cand_nx, active, active_nx;
  logic [MW-1:0]     match, match_nx;
  logic [SW-1:0]     miss, miss_nx;
  logic              pv_nx;

  // sync[1:0] is the metastability pair, sync[2] the previous sample for edge detect
  assign rise = sync[1] & ~sync[2];

  // later tests override earlier ones so the lowest band wins on overlap
  always_comb begin
    band = 3'd0;
    if (cnt >= L4 && cnt <= H4) band = 3'd4;
    if (cnt >= L3 && cnt <= H3) band = 3'd3;
    if (cnt >= L2 && cnt <= H2) band = 3'd2;
    if (cnt >= L1 && cnt <= H1) band = 3'd1;
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    cand_nx   = cand;
    match_nx  = match;
    miss_nx   = miss;
    active_nx = active;
    per_nx    = period_out;
    pv_nx     = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_nx = MEASURE;
        cnt_nx   = CNT_W'(1);
      end
      MEASURE: begin
        if (rise) begin
          per_nx  = cnt;
          pv_nx   = 1'b1;
          cnt_nx  = CNT_W'(1);
          cand_nx = band;
          if (band == cand) match_nx = (match == MATCH_V) ? match : match + 1'b1;
          else              match_nx = MW'(1);
          if (active != 3'd0) miss_nx = (band != active) ? miss + 1'b1 : '0;
          // activation takes precedence over a drop decided on the same period
          if (band != 3'd0 && match_nx == MATCH_V) begin
            active_nx = band;
            miss_nx   = '0;
          end else if (miss_nx == MISS_V) begin
            active_nx = 3'd0;
            miss_nx   = '0;
          end
        end else if (cnt == TO) begin
          state_nx  = IDLE;
          cand_nx   = 3'd0;
          match_nx  = '0;
          miss_nx   = '0;
          active_nx = 3'd0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sync         <= '0;
      cnt          <= '0;
      cand         <= '0;
      match        <= '0;
      miss         <= '0;
      active       <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      sync         <= {sync[1:0], tone_in};
      cnt          <= cnt_nx;
      cand         <= cand_nx;
      match        <= match_nx;
      miss         <= miss_nx;
      active       <= active_nx;
      period_out   <= per_nx;
      period_valid <= pv_nx;
    end
  end

  assign pb1 = (active == 3'd1);
  assign pb2 = (active == 3'd2);
  assign pb3 = (active == 3'd3);
  assign pb4 = (active == 3'd4);
endmodule
